// File: rtl/pix_pack_pkg.sv
// Shared constants and types for the 4-lane 12-bit pixel to 128-bit word packer.
package pix_pack_pkg;

  localparam int PIX_W  = 12;
  localparam int LANES  = 4;
  localparam int BEAT_W = PIX_W * LANES;
  localparam int WORD_W = 128;
  localparam int ACC_W  = WORD_W + BEAT_W;
  localparam int FILL_W = 8;

  typedef struct packed {
    logic              sof;
    logic              eol;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_t;

endpackage

// File: rtl/pack_sync_fifo.sv
// Single-clock first-word-fall-through FIFO: rd_data shows the head entry whenever !empty.
module pack_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_ok   = rd_en & ~empty;
  // a pop frees the head slot in the same cycle, so a push while full still lands
  assign wr_ok   = wr_en & (~full | rd_ok);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pix4_ddr_packer.sv
// Packs 4-lane 12-bit pixel beats into 128-bit words with frame/line markers behind a FWFT FIFO.
// Build option PACK_TESTPAT_EN: test_mode replaces pixels with a per-line ramp.
//   state     | meaning
//   ST_IDLE   | waiting for fval rising edge; beats ignored
//   ST_ACTIVE | inside a frame; beats packed, lines counted
module pix4_ddr_packer
  import pix_pack_pkg::*;
#(
  parameter int LINE_BEATS = 512,
  parameter int FIFO_DEPTH = 8,
  parameter int FCNT_W     = 16
) (
  input  logic              clk_txg,
  input  logic              rst_tx,
  input  logic              fval,
  input  logic              lval,
  input  logic [PIX_W-1:0]  chan_f0,
  input  logic [PIX_W-1:0]  chan_f1,
  input  logic [PIX_W-1:0]  chan_f2,
  input  logic [PIX_W-1:0]  chan_f3,
  input  logic              test_mode,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_sof,
  output logic              dout_eol,
  output logic              ovf,
  output logic              line_err,
  input  logic              err_clr,
  output logic [11:0]       line_cnt,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int BC_W = $clog2(LINE_BEATS + 1) + 1;

  logic                        fval_q, lval_q, fval_d;
  logic [BEAT_W-1:0]           pix_q, beat_pix;
  frame_state_t                state, state_nxt;
  logic                        fval_rise, fval_fall, arm, frame_done, active;
  logic                        beat, line_end, in_line, sof_armed;
  logic [BC_W-1:0]             beat_cnt;
  logic [ACC_W-1:0]            acc, acc_sum;
  logic [FILL_W-1:0]           fill, fill_sum;
  logic                        word_full, push_norm, push_flush;
  logic [WORD_W-1:0]           word;
  logic                        word_vld, word_sof, word_flush, word_eol;
  logic                        pop, fifo_full, fifo_empty, ovf_evt;
  fifo_entry_t                 wr_entry, rd_entry;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_cnt;

  // Input stage is free-running so a reset inside a frame cannot fake an fval edge.
  always_ff @(posedge clk_txg) begin
    fval_q <= fval;
    lval_q <= lval;
    fval_d <= fval_q;
    pix_q  <= {chan_f3, chan_f2, chan_f1, chan_f0};
  end

`ifdef PACK_TESTPAT_EN
  logic test_mode_q;
  always_ff @(posedge clk_txg) test_mode_q <= test_mode;

  always_comb begin
    beat_pix = pix_q;
    if (test_mode_q) begin
      for (int k = 0; k < LANES; k++)
        beat_pix[k*PIX_W +: PIX_W] = PIX_W'(int'(beat_cnt) * LANES + k);
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign beat_pix         = pix_q;
`endif

  assign fval_rise = fval_q & ~fval_d;
  assign fval_fall = ~fval_q & fval_d;

  always_ff @(posedge clk_txg) begin
    if (rst_tx) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (fval_rise) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (fval_fall) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    arm        = 1'b0;
    frame_done = 1'b0;
    active     = 1'b0;
    case (state)
      ST_IDLE: begin
        arm    = fval_rise;
        active = fval_rise;
      end
      ST_ACTIVE: begin
        active     = 1'b1;
        frame_done = fval_fall;
      end
      default: ;
    endcase
  end

  assign beat       = active & fval_q & lval_q;
  assign line_end   = in_line & ~(fval_q & lval_q);
  assign acc_sum    = acc | (ACC_W'(beat_pix) << fill);
  assign fill_sum   = fill + FILL_W'(BEAT_W);
  assign word_full  = (fill_sum >= FILL_W'(WORD_W));
  assign push_norm  = beat & word_full;
  assign push_flush = line_end & (fill != '0);

  // One-word holding stage lets the last word of a line pick up eol once the line end is seen.
  always_ff @(posedge clk_txg) begin
    if (rst_tx) begin
      acc        <= '0;
      fill       <= '0;
      in_line    <= 1'b0;
      beat_cnt   <= '0;
      sof_armed  <= 1'b0;
      word       <= '0;
      word_vld   <= 1'b0;
      word_sof   <= 1'b0;
      word_flush <= 1'b0;
    end else begin
      word_vld <= push_norm | push_flush;
      if (push_norm | push_flush) begin
        word_sof   <= sof_armed;
        word_flush <= push_flush;
        word       <= push_norm ? acc_sum[WORD_W-1:0] : acc[WORD_W-1:0];
      end
      if (arm)                          sof_armed <= 1'b1;
      else if (push_norm | push_flush)  sof_armed <= 1'b0;
      if (beat) begin
        in_line <= 1'b1;
        if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
        if (word_full) begin
          acc  <= acc_sum >> WORD_W;
          fill <= fill_sum - FILL_W'(WORD_W);
        end else begin
          acc  <= acc_sum;
          fill <= fill_sum;
        end
      end else if (line_end) begin
        in_line  <= 1'b0;
        beat_cnt <= '0;
        acc      <= '0;
        fill     <= '0;
      end
    end
  end

  assign word_eol = word_flush | (line_end & (fill == '0));
  assign pop      = dout_valid & dout_ready;
  assign ovf_evt  = word_vld & fifo_full & ~pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.sof  = word_sof;
    wr_entry.eol  = word_eol;
    wr_entry.data = word;
  end

  pack_sync_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk_txg),
    .rst    (rst_tx),
    .wr_en  (word_vld),
    .wr_data(wr_entry),
    .rd_en  (pop),
    .rd_data(rd_entry),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (unused_fifo_cnt)
  );

  assign dout       = rd_entry.data;
  assign dout_valid = ~fifo_empty;
  assign dout_sof   = rd_entry.sof & ~fifo_empty;
  assign dout_eol   = rd_entry.eol & ~fifo_empty;

  always_ff @(posedge clk_txg) begin
    if (rst_tx) begin
      line_cnt  <= '0;
      frame_cnt <= '0;
      line_err  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (arm)                               line_cnt <= '0;
      else if (line_end && line_cnt != '1)   line_cnt <= line_cnt + 1'b1;
      if (frame_done) frame_cnt <= frame_cnt + 1'b1;
      if (line_end && beat_cnt != BC_W'(LINE_BEATS)) line_err <= 1'b1;
      else if (err_clr)                              line_err <= 1'b0;
      if (ovf_evt)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pix4_ddr_packer.sv
// Randomized bench for pix4_ddr_packer: words are predicted from each line's pixel stream.
`timescale 1ns/1ps
module tb_pix4_ddr_packer;
  import pix_pack_pkg::*;

  localparam int LINE_BEATS = 512;
  localparam int FIFO_DEPTH = 8;
  localparam int FCNT_W     = 16;

  logic              clk_txg = 1'b0;
  logic              rst_tx, fval, lval, test_mode, dout_ready, err_clr;
  logic [11:0]       chan_f0, chan_f1, chan_f2, chan_f3;
  logic [127:0]      dout;
  logic              dout_valid, dout_sof, dout_eol, ovf, line_err;
  logic [11:0]       line_cnt;
  logic [FCNT_W-1:0] frame_cnt;

  always #5 clk_txg = ~clk_txg;

  pix4_ddr_packer #(
    .LINE_BEATS(LINE_BEATS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .FCNT_W    (FCNT_W)
  ) dut (
    .clk_txg   (clk_txg),
    .rst_tx    (rst_tx),
    .fval      (fval),
    .lval      (lval),
    .chan_f0   (chan_f0),
    .chan_f1   (chan_f1),
    .chan_f2   (chan_f2),
    .chan_f3   (chan_f3),
    .test_mode (test_mode),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_sof  (dout_sof),
    .dout_eol  (dout_eol),
    .ovf       (ovf),
    .line_err  (line_err),
    .err_clr   (err_clr),
    .line_cnt  (line_cnt),
    .frame_cnt (frame_cnt)
  );

  typedef logic [129:0] ent_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  ent_t        got_q[$];
  ent_t        exp_q[$];
  logic [11:0] line_pix[$];
  bit          sof_pend, exp_lerr, exp_ovf, lat_probe;
  int          exp_lines, exp_frames, ready_mode;
  int          first_valid_cyc = -1;
  int          lat_edge = -1;

  always @(posedge clk_txg) cyc <= cyc + 1;

  always @(negedge clk_txg) begin
    if (!rst_tx) begin
      if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (dout_valid && dout_ready) got_q.push_back({dout_sof, dout_eol, dout});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_txg);
    #1;
    if (ready_mode == 2) dout_ready = ($urandom_range(3) != 0);
    else                 dout_ready = (ready_mode == 1);
  endtask

  // mode 0: pixel = index in line, 1: random, 2: random on the pins but ramp expected
  task automatic drive_beat(input int b, input int mode);
    logic [11:0] p[4];
    for (int k = 0; k < 4; k++) begin
      p[k] = (mode == 0) ? 12'(4 * b + k) : 12'($urandom_range(4095));
      line_pix.push_back((mode == 2) ? 12'(4 * b + k) : p[k]);
    end
    chan_f0 = p[0];
    chan_f1 = p[1];
    chan_f2 = p[2];
    chan_f3 = p[3];
  endtask

  task automatic model_line_end(input int nbeats);
    int nbits, nw, gb;
    logic [127:0] d;
    logic [11:0]  pv;
    nbits = line_pix.size() * 12;
    nw    = (nbits + 127) / 128;
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int b = 0; b < 128; b++) begin
        gb = w * 128 + b;
        if (gb < nbits) begin
          pv   = line_pix[gb / 12];
          d[b] = pv[gb % 12];
        end
      end
      exp_q.push_back({sof_pend, (w == nw - 1), d});
      sof_pend = 1'b0;
    end
    line_pix.delete();
    if (exp_lines < 4095) exp_lines++;
    if (nbeats != LINE_BEATS) exp_lerr = 1'b1;
  endtask

  task automatic frame_start();
    fval = 1'b1;
    lval = 1'b0;
    tick();
    tick();
    sof_pend  = 1'b1;
    exp_lines = 0;
  endtask

  task automatic frame_end();
    fval = 1'b0;
    tick();
    tick();
    exp_frames++;
  endtask

  task automatic send_line(input int nbeats, input int mode, input bit fval_end);
    for (int b = 0; b < nbeats; b++) begin
      lval = 1'b1;
      drive_beat(b, mode);
      if (lat_probe && b == 2) begin
        lat_edge  = cyc + 1;
        lat_probe = 1'b0;
      end
      tick();
    end
    if (fval_end) begin
      fval = 1'b0;
      tick();
      lval = 1'b0;
      model_line_end(nbeats);
      exp_frames++;
      tick();
      tick();
    end else begin
      lval = 1'b0;
      model_line_end(nbeats);
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  task automatic drain(input string tag);
    repeat (6) tick();
    for (int i = 0; i < 500 && dout_valid; i++) tick();
    check_val({tag, "_drain"}, dout_valid, 0);
  endtask

  task automatic compare_words(input string tag);
    check_val({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_val($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag);
    check_val({tag, "_line_cnt"}, line_cnt, exp_lines);
    check_val({tag, "_frame_cnt"}, frame_cnt, 16'(exp_frames));
    check_val({tag, "_ovf"}, ovf, exp_ovf);
    check_val({tag, "_line_err"}, line_err, exp_lerr);
  endtask

  task automatic clear_err(input string tag);
    err_clr = 1'b1;
    tick();
    err_clr  = 1'b0;
    exp_lerr = 1'b0;
    exp_ovf  = 1'b0;
    check_val({tag, "_clr_line_err"}, line_err, 0);
    check_val({tag, "_clr_ovf"}, ovf, 0);
  endtask

  initial begin
    int nl, nb;
    bit fe;
    rst_tx = 1'b1; fval = 1'b0; lval = 1'b0; test_mode = 1'b0; err_clr = 1'b0;
    chan_f0 = '0; chan_f1 = '0; chan_f2 = '0; chan_f3 = '0;
    ready_mode = 1; dout_ready = 1'b1;
    sof_pend = 1'b0; exp_lerr = 1'b0; exp_ovf = 1'b0; exp_lines = 0; exp_frames = 0;
    lat_probe = 1'b0;
    repeat (4) tick();
    rst_tx = 1'b0;
    tick();
    check_val("rst_valid", dout_valid, 0);
    check_val("rst_sof", dout_sof, 0);
    check_val("rst_eol", dout_eol, 0);
    check_status("rst");

    // two full lines of index pixels, always ready
    lat_probe = 1'b1;
    frame_start();
    send_line(LINE_BEATS, 0, 1'b0);
    send_line(LINE_BEATS, 0, 1'b0);
    frame_end();
    drain("t1");
    check_val("t1_latency", first_valid_cyc, lat_edge + 2);
    compare_words("t1");
    check_status("t1");

    // short line with a flush word, then random frames under random backpressure
    ready_mode = 2;
    frame_start();
    send_line(3, 1, 1'b0);
    send_line($urandom_range(1, 40), 1, 1'b0);
    frame_end();
    drain("t2");
    compare_words("t2");
    check_status("t2");
    clear_err("t2");
    for (int f = 0; f < 4; f++) begin
      nl = $urandom_range(0, 4);
      frame_start();
      fe = 1'b0;
      for (int l = 0; l < nl; l++) begin
        nb = $urandom_range(1, 40);
        fe = (l == nl - 1) && ($urandom_range(1) == 1);
        send_line(nb, 1, fe);
      end
      if (!fe) frame_end();
      drain($sformatf("r%0d", f));
      compare_words($sformatf("r%0d", f));
      check_status($sformatf("r%0d", f));
    end
    clear_err("r");

    // no reads for a whole line: only the first FIFO_DEPTH words survive
    ready_mode = 0;
    frame_start();
    send_line(LINE_BEATS, 1, 1'b0);
    frame_end();
    while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
    exp_ovf = 1'b1;
    check_val("t3_valid_held", dout_valid, 1);
    check_status("t3");
    ready_mode = 1;
    drain("t3");
    compare_words("t3");
    clear_err("t3");

    // fval drops while lval is still high
    ready_mode = 2;
    frame_start();
    send_line(5, 1, 1'b1);
    drain("t4");
    compare_words("t4");
    check_status("t4");
    clear_err("t4");

    // reset in the middle of a line
    ready_mode = 1;
    frame_start();
    for (int b = 0; b < 300; b++) begin
      lval = 1'b1;
      drive_beat(b, 1);
      tick();
    end
    drive_beat(300, 1);
    rst_tx = 1'b1;
    tick();
    check_val("t5_rst_valid", dout_valid, 0);
    check_val("t5_rst_line_cnt", line_cnt, 0);
    check_val("t5_rst_frame_cnt", frame_cnt, 0);
    tick();
    rst_tx = 1'b0;
    for (int b = 0; b < 20; b++) begin
      drive_beat(b, 1);
      tick();
    end
    lval = 1'b0;
    tick();
    fval = 1'b0;
    tick();
    tick();
    line_pix.delete();
    got_q.delete();
    exp_q.delete();
    exp_lines = 0; exp_frames = 0; exp_lerr = 1'b0; exp_ovf = 1'b0; sof_pend = 1'b0;
    check_val("t5_idle_valid", dout_valid, 0);
    check_status("t5_idle");
    frame_start();
    send_line(10, 1, 1'b0);
    frame_end();
    drain("t5");
    compare_words("t5");
    check_status("t5");
    clear_err("t5");

`ifdef PACK_TESTPAT_EN
    test_mode = 1'b1;
    frame_start();
    send_line(8, 2, 1'b0);
    send_line(6, 2, 1'b0);
    frame_end();
    drain("t6");
    if (got_q.size() > 0) begin
      ent_t w0;
      w0 = got_q[0];
      check_val("t6_px10_low", w0[127:120], 8'd10);
    end
    compare_words("t6");
    check_status("t6");
    test_mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pix4_ddr_packer.md
Name: pix4_ddr_packer

Overview:
- Sits directly downstream of the 8-to-4 channel line re-order stage, in the clk_txg domain.
- Consumes 4 lanes of 12-bit pixels plus regenerated fval/lval, and packs them into 128-bit words for the DDR3 write path.
- Provides a small output FIFO with valid/ready backpressure, frame and line markers, and sticky error/overflow status.
- The input cannot be stalled, so any loss is flagged rather than back-pressured.

Parameters:
- LINE_BEATS, 512: expected lval-high beats per line, used for line-length check.
- FIFO_DEPTH, 8: output FIFO entries; power of 2, minimum 4.
- FCNT_W, 16: frame counter width.

Ports:
- clk_txg  in  1  pixel/output clock; single clock domain.
- rst_tx  in  1  synchronous, active-high reset.
- fval  in  1  frame valid from re-order stage.
- lval  in  1  line valid; a beat is every cycle with fval&lval.
- chan_f0..chan_f3  in  12 each  lane pixels; f0 is the lowest pixel of the beat.
- test_mode  in  1  test pattern select; used only with PACK_TESTPAT_EN.
- dout  out  128  packed word.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer accepts when dout_valid&dout_ready.
- dout_sof  out  1  dout is the first word of a frame.
- dout_eol  out  1  dout is the last word of a line.
- ovf  out  1  sticky: a word was dropped because the FIFO was full.
- line_err  out  1  sticky: a line's beat count was not equal to LINE_BEATS.
- err_clr  in  1  clears ovf and line_err; set-priority if a set event occurs in the same cycle.
- line_cnt  out  12  lines completed in the current frame.
- frame_cnt  out  FCNT_W  frames completed; wraps.

Behaviour:
- Reset: dout_valid, dout_sof, dout_eol, ovf and line_err are 0; line_cnt and frame_cnt are 0; the FIFO is empty; the accumulator is cleared. Reset mid-line discards all partial data; packing restarts at the next fval rising edge.
- Inputs are registered once.
- Beat: {chan_f3,chan_f2,chan_f1,chan_f0} = 48 bits, appended above the current fill of a 176-bit accumulator. Earlier pixels occupy lower bits.
- fill=0..160 in steps of 16. When fill+48 >= 128, the low 128 bits are pushed and the remainder is shifted down. The steady pattern is 3 words per 8 beats.
- Latency: a beat sampled at edge N that completes a word gives dout_valid high after edge N+2 (FIFO is first-word fall-through).
- Line end (registered lval 1->0, or fval falls while lval high):
  - If fill>0, push one flush word with the remainder zero-padded in the upper bits.
  - The last pushed word of the line has eol=1.
  - line_cnt increments.
  - If the beat count is not equal to LINE_BEATS, line_err is set.
  - If a normal push and a flush are both needed, the normal push occurs first and the flush follows the next cycle. The input is idle then, so no conflict arises.
- Frame FSM, states IDLE -> ACTIVE -> IDLE:
  - IDLE->ACTIVE on fval rising: line_cnt is cleared and the sof flag is armed. Beats while in IDLE are ignored.
  - The first pushed word after arming carries sof=1, then the flag is disarmed.
  - ACTIVE->IDLE on fval falling, after any flush: frame_cnt increments.
  - A frame with zero lines still counts, but emits no words.
- FIFO: each entry holds {sof,eol,data}.
  - A push when full drops the word and sets ovf. A pop in the same cycle frees a slot first, so a simultaneous push and pop when full is not an overflow.
  - dout, dout_sof and dout_eol are held stable while dout_valid&!dout_ready.
- line_cnt saturates at 4095; frame_cnt wraps modulo 2^FCNT_W.

Optional Feature:
- Macro: PACK_TESTPAT_EN.
- Defined:
  - When test_mode=1, lane k pixel = (4*beat_index_in_line + k) mod 4096; beat_index resets at each line start.
  - fval/lval timing, markers and counters are unchanged.
- Undefined: test_mode is ignored; the pattern logic is absent.

Decomposition:
- Package pix_pack_pkg holds:
  - Constants: PIX_W=12, LANES=4, BEAT_W=48, WORD_W=128, ACC_W=176.
  - A typedef for the FIFO entry struct {sof,eol,data}.
- Sub-module pack_sync_fifo: single-clock FWFT FIFO, parameterised on width and depth, providing full, empty and count.

Test Plan:
1. Reset, then 1 frame of 2 lines × 512 beats with pixel value = index, dout_ready=1 -> 192 words per line with no flush. Word0 = pixels 0..9 plus the low 8 bits of pixel 10, sof=1 on word0 only, eol on words 191 and 383. line_cnt=2, frame_cnt=1, no errors.
2. Line of 3 beats -> words: one full word, then a flush with bits[127:16] = 0 and eol=1. line_err=1; err_clr drops it to 0.
3. dout_ready=0 for a full 512-beat line with FIFO_DEPTH=8 -> 8 words retained, ovf=1, and the retained words are the first 8 of the line, in order.
4. fval falls while lval is high after 5 beats -> flush word with eol=1 is pushed, then frame_cnt increments, line_cnt=1.
5. rst_tx asserted at beat 300 of a line -> dout_valid=0 next cycle. The next frame's word0 carries sof and contains new data only.
6. PACK_TESTPAT_EN defined, test_mode=1 -> word0 lanes hold 0,1,...,9 in 12-bit fields, and pixel 10 (value 10) begins at bit 120.
